// File: rtl/pwm_decoder_if.sv
// Sync/PWM inputs and Duty/Valid/SyncLost results of the PWM duty decoder.
// Latency and backpressure are set by the decoder; this bundle only groups the signals.
interface pwm_decoder_if #(
  parameter int DutyN = 24
);
  logic             Sync;
  logic             PWM;
  logic [DutyN-1:0] Duty;
  logic             Valid;
  logic             SyncLost;

  modport master (output Sync, PWM, input Duty, Valid, SyncLost);
  modport slave  (input Sync, PWM, output Duty, Valid, SyncLost);
endinterface

// File: rtl/pwm_decoder.sv
// PWM duty decoder: counts high clocks per Sync frame, averages 2^AvgN frames into a DutyN-bit word.
// Valid pulses one clock after the closing Sync edge; free-running strobe, no backpressure.
module pwm_decoder #(
  parameter int DutyN  = 24,
  parameter int FrameN = 8,
  parameter int AvgN   = 4
) (
  input logic         nReset,
  input logic         Clk,
  pwm_decoder_if.slave bus
);
  localparam int SumW  = FrameN + AvgN + 1;
  localparam int FcW   = (AvgN > 0) ? AvgN : 1;
  localparam int LenW  = FrameN + 2;
  localparam int Shift = DutyN - FrameN - AvgN;

  localparam logic [FrameN:0]  HighMax    = {1'b1, {FrameN{1'b0}}};
  localparam logic [FrameN:0]  HighOne    = (FrameN+1)'(1);
  localparam logic [FcW-1:0]   LastFrame  = FcW'((1 << AvgN) - 1);
  localparam logic [FcW-1:0]   FrameOne   = FcW'(1);
  // One below 2^(FrameN+1): SyncLost is raised on the clock LenCnt steps onto the limit.
  localparam logic [LenW-1:0]  LenTimeout = LenW'((1 << (FrameN + 1)) - 1);
  localparam logic [LenW-1:0]  LenMax     = '1;
  localparam logic [LenW-1:0]  LenOne     = LenW'(1);
  localparam logic [SumW-1:0]  SumFull    = SumW'(1) << (FrameN + AvgN);

  logic             pwm_meta;
  logic             pwm_s;
  logic             p_sync;
  logic [FrameN:0]  high_cnt;
  logic [LenW-1:0]  len_cnt;
  logic [SumW-1:0]  acc;
  logic [FcW-1:0]   frame_cnt;
  logic             started;
  logic [DutyN-1:0] duty;
  logic             valid;
  logic             sync_lost;

  logic             sync_edge;
  logic             timeout;
  logic [SumW-1:0]  sum;
  logic [DutyN-1:0] scaled;

  assign sync_edge = !p_sync && bus.Sync;
  assign timeout   = !sync_edge && (len_cnt == LenTimeout);
  assign sum       = acc + SumW'(high_cnt);

  // An always-high window would shift to exactly 2^DutyN, so clamp it to full scale.
  always_comb begin
    scaled = DutyN'(sum) << Shift;
    if (sum == SumFull) begin
      scaled = '1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pwm_meta  <= 1'b0;
      pwm_s     <= 1'b0;
      p_sync    <= 1'b1;
      high_cnt  <= '0;
      len_cnt   <= '0;
      acc       <= '0;
      frame_cnt <= '0;
      started   <= 1'b0;
      duty      <= '0;
      valid     <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      pwm_meta <= bus.PWM;
      pwm_s    <= pwm_meta;
      p_sync   <= bus.Sync;
      valid    <= 1'b0;

      if (sync_edge) begin
        high_cnt <= {{FrameN{1'b0}}, pwm_s};
      end else if (pwm_s && (high_cnt != HighMax)) begin
        high_cnt <= high_cnt + HighOne;
      end

      if (sync_edge) begin
        len_cnt <= '0;
      end else if (len_cnt != LenMax) begin
        len_cnt <= len_cnt + LenOne;
      end

      if (sync_edge) begin
        sync_lost <= 1'b0;
        if (!started) begin
          // First edge after reset or loss: the partial frame before it is discarded.
          started   <= 1'b1;
          acc       <= '0;
          frame_cnt <= '0;
        end else if (frame_cnt == LastFrame) begin
          acc       <= '0;
          frame_cnt <= '0;
          duty      <= scaled;
          valid     <= 1'b1;
        end else begin
          acc       <= sum;
          frame_cnt <= frame_cnt + FrameOne;
        end
      end else if (timeout) begin
        sync_lost <= 1'b1;
        started   <= 1'b0;
      end
    end
  end

  assign bus.Duty     = duty;
  assign bus.Valid    = valid;
  assign bus.SyncLost = sync_lost;
endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: 256-clock Sync frames with hand-computed window sums.
module tb_pwm_decoder;
  localparam int DutyN  = 24;
  localparam int FrameN = 8;
  localparam int AvgN   = 4;

  logic Clk = 1'b0;
  logic nReset;
  always #5 Clk = ~Clk;

  pwm_decoder_if #(.DutyN(DutyN)) bus ();

  pwm_decoder #(.DutyN(DutyN), .FrameN(FrameN), .AvgN(AvgN)) dut (
    .nReset (nReset),
    .Clk    (Clk),
    .bus    (bus)
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  logic [DutyN-1:0] last_duty = '0;
  int sl_rise_cyc = 0;
  int sl_fall_cyc = 0;
  logic prev_sl = 1'b0;
  int last_edge_cyc = 0;
  int win_edge_cyc = 0;
  int e0, le, r, vb;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (nReset === 1'b1) begin
      if (bus.Valid === 1'b1) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        last_duty = bus.Duty;
      end
      if (bus.SyncLost === 1'b1 && !prev_sl) sl_rise_cyc = cyc;
      if (bus.SyncLost === 1'b0 && prev_sl) sl_fall_cyc = cyc;
      prev_sl = (bus.SyncLost === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PWM is high on frame offsets [hs, hs+hl); Sync pulses for one clock at offset 0.
  task automatic run_frame(input int hs, input int hl, input bit sync_on);
    for (int i = 0; i < 256; i++) begin
      @(negedge Clk);
      if (sync_on && i == 0 && bus.Sync == 1'b0) last_edge_cyc = cyc;
      bus.Sync = sync_on && (i == 0);
      bus.PWM  = (i >= hs) && (i < hs + hl);
    end
  endtask

  task automatic run_window(input int hs, input int hl0, input int hl1);
    for (int f = 0; f < 16; f++) begin
      run_frame(hs, (f % 2 == 0) ? hl0 : hl1, 1'b1);
      if (f == 0) win_edge_cyc = last_edge_cyc;
    end
    #2;
  endtask

  initial begin
    nReset   = 1'b0;
    bus.Sync = 1'b1;
    bus.PWM  = 1'b1;
    repeat (3) @(negedge Clk);
    #1;
    chk("reset_duty", bus.Duty, 0);
    chk("reset_valid", bus.Valid, 0);
    chk("reset_synclost", bus.SyncLost, 0);
    nReset = 1'b1;
    repeat (5) @(negedge Clk);
    #2;
    chk("release_duty", bus.Duty, 0);
    chk("release_valid_cnt", valid_cnt, 0);
    chk("release_synclost", bus.SyncLost, 0);

    // Sync is already high here, so this frame's offset 0 is not an edge.
    run_frame(100, 64, 1'b1);
    run_window(100, 64, 64);
    e0 = win_edge_cyc;
    chk("const_no_early_valid", valid_cnt, 0);
    run_window(100, 64, 64);
    chk("const_first_cnt", valid_cnt, 1);
    chk("const_first_time", last_valid_cyc, e0 + 4097);
    chk("const_first_duty", last_duty, 24'h400000);

    run_window(0, 256, 256);
    chk("const_second_cnt", valid_cnt, 2);
    chk("const_second_time", last_valid_cyc, e0 + 8193);
    chk("const_second_duty", last_duty, 24'h400000);
    run_window(0, 256, 256);
    chk("high_transition_duty", last_duty, 24'hFFE000);
    run_window(0, 0, 0);
    chk("high_saturated_duty", last_duty, 24'hFFFFFF);
    run_window(0, 0, 0);
    chk("low_transition_duty", last_duty, 24'h002000);
    run_window(100, 100, 101);
    chk("low_duty", last_duty, 24'h000000);
    run_window(100, 100, 101);
    chk("dither_duty", last_duty, 24'h648000);

    repeat (5) run_frame(100, 64, 1'b1);
    #2;
    chk("dither_repeat_duty", last_duty, 24'h648000);
    chk("pre_loss_synclost", bus.SyncLost, 0);
    vb = valid_cnt;
    le = last_edge_cyc;
    repeat (3) run_frame(100, 64, 1'b0);
    #2;
    chk("loss_time", sl_rise_cyc - le, 513);
    chk("loss_level", bus.SyncLost, 1);
    chk("loss_no_valid", valid_cnt, vb);
    chk("loss_duty_hold", bus.Duty, 24'h648000);

    run_window(100, 64, 64);
    r = win_edge_cyc;
    chk("restart_clear_time", sl_fall_cyc, r + 1);
    chk("restart_level", bus.SyncLost, 0);
    chk("restart_no_valid", valid_cnt, vb);
    run_window(100, 64, 64);
    chk("restart_valid_cnt", valid_cnt, vb + 1);
    chk("restart_valid_time", last_valid_cyc, r + 4097);
    chk("restart_duty", last_duty, 24'h400000);

    repeat (7) run_frame(100, 32, 1'b1);
    @(negedge Clk);
    nReset   = 1'b0;
    bus.Sync = 1'b0;
    bus.PWM  = 1'b0;
    #1;
    chk("midreset_duty", bus.Duty, 0);
    chk("midreset_valid", bus.Valid, 0);
    chk("midreset_synclost", bus.SyncLost, 0);
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    vb = valid_cnt;
    repeat (10) @(negedge Clk);
    run_window(100, 32, 32);
    r = win_edge_cyc;
    chk("midreset_no_early_valid", valid_cnt, vb);
    run_window(100, 32, 32);
    chk("midreset_valid_cnt", valid_cnt, vb + 1);
    chk("midreset_valid_time", last_valid_cyc, r + 4097);
    chk("midreset_duty_value", last_duty, 24'h200000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
Measures the duty cycle of an incoming, possibly noise-shaped, PWM stream and recovers a high-resolution duty word. Counts high clocks in each PWM frame. Frames are delimited by the same Sync strobe (fClk / 2^FrameN) that drives the PWM generator. Accumulates 2^AvgN frames and emits one scaled DutyN-bit sample with a one-cycle Valid strobe. Sits on the loop-back/measurement side of PWM outputs (self-test, closed-loop control, recovery of a received PWM link).

Parameters:
DutyN, 24, width of recovered duty word; must be >= FrameN+AvgN.
FrameN, 8, log2 of clocks per PWM frame.
AvgN, 4, log2 of frames averaged per output sample; 0 means one sample per frame.

Ports:
nReset  input  1  Asynchronous, active-low reset.
Clk  input  1  System clock, same domain as Sync.
Sync  input  1  Frame strobe, synchronous to Clk; its rising edge marks frame start.
PWM  input  1  Asynchronous PWM input.
Duty  output  DutyN  Recovered duty; full scale 2^DutyN-1 means always high.
Valid  output  1  One-cycle strobe when Duty updates.
SyncLost  output  1  High while no Sync edge has been seen for 2^(FrameN+1) clocks.

Behaviour:
- Reset (nReset low, asynchronous):
  - Duty=0, Valid=0, SyncLost=0.
  - All counters and the accumulator are 0.
  - pSync=1, so a Sync already high at reset release is not an edge.
  - Synchronizer flops are 0.
  - Started=0.
- Input path: PWM passes through a 2-flop synchronizer to give PWMs. The fixed 2-clock skew versus Sync is not compensated; for a constant duty the per-frame high count is phase-insensitive.
- Edge: Edge = (pSync==0 && Sync==1) using a registered pSync. The Edge cycle is the first cycle of the new frame.
- HighCnt (FrameN+1 bits):
  - On a non-Edge cycle it increments when PWMs=1, saturating at 2^FrameN.
  - On an Edge cycle it loads PWMs (0 or 1).
- Started flag:
  - Before the first Edge after reset or after SyncLost, nothing is accumulated.
  - The first Edge sets Started=1 and clears Acc, FrameCnt and HighCnt. The partial frame is discarded.
- Accumulation, on an Edge with Started=1:
  - Sum = Acc + HighCnt (FrameN+AvgN+1 bits).
  - If FrameCnt == 2^AvgN-1: Acc<=0, FrameCnt<=0, Duty<=Scale(Sum), Valid<=1.
  - Otherwise: Acc<=Sum, FrameCnt<=FrameCnt+1 (AvgN bits, wraps).
- Scale(Sum): Sum << (DutyN-FrameN-AvgN). If Sum == 2^(FrameN+AvgN) (always high), the result is 2^DutyN-1 (saturated).
- Latency and Valid timing:
  - Valid is high exactly the one clock after the closing Edge; otherwise 0.
  - Duty holds its value between Valid strobes.
- Frame length:
  - LenCnt (FrameN+2 bits) clears on Edge and increments otherwise, saturating.
  - When LenCnt reaches 2^(FrameN+1): SyncLost<=1, Started<=0. The running average is abandoned, no Valid is issued, and Duty holds its last value.
  - The next Edge clears SyncLost and restarts as a first Edge, again discarding that partial frame.
- Short frames: an Edge earlier than 2^FrameN clocks is accepted as-is. The count simply reflects the shorter window; no error is flagged.
- Simultaneous events: Edge in the same cycle as LenCnt reaching the timeout means Edge wins; SyncLost stays 0.
- Reset mid-average: everything is discarded per the reset values. The first Valid comes 2^AvgN full frames after the first post-reset Edge.

Test Plan:
(All scenarios use defaults DutyN=24, FrameN=8, AvgN=4; Sync period 256 clocks.)
- Reset: assert nReset with Sync=1 and PWM=1, then release. Required: Duty=0, Valid=0, SyncLost=0; no Edge is detected until Sync falls and rises again.
- Constant duty: 64 high clocks per frame. Required: first Valid 16 full frames after the first Edge (+1 clock), then every 4096 clocks; Duty=0x400000 each time.
- Extremes:
  - PWM held 1: Duty=0xFFFFFF (saturation path).
  - PWM held 0: Duty=0x000000.
- Dither: frames alternate 100/101 high clocks, 8 of each per window. Required: Sum=1608, Duty=0x648000.
- Sync loss: stop Sync mid-window. Required: SyncLost=1 exactly 512 clocks after the last Edge; no Valid; Duty unchanged. Restart Sync: SyncLost=0 at the first Edge, next Valid after 16 further full frames.
- Reset mid-window: pulse nReset after 7 frames. Required: Duty=0 immediately; first Valid 16 complete frames after the first post-reset Edge, value matching the applied duty.
